// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative IEEE-754 divider.
// Holds the FSM state encoding, the flag bit positions and helpers that
// build the infinity / canonical quiet-NaN encodings for any EXP_W/MAN_W.
package fp_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // Flag vector layout: {invalid, div_by_zero, overflow, underflow, inexact}
    localparam int FLG_W  = 5;
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Helpers return a wide word; callers keep the low 1+EXP_W+MAN_W bits.
    localparam int MAX_WORD = 128;

    // Positive infinity: exponent all ones, fraction zero.
    function automatic logic [MAX_WORD-1:0] fp_inf(input int exp_w, input int man_w);
        logic [MAX_WORD-1:0] ones;
        ones = (MAX_WORD'(1) << exp_w) - MAX_WORD'(1);
        return ones << man_w;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [MAX_WORD-1:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (MAX_WORD'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand / result handshake bundle for fp_div_iter.
// master drives operands and accepts results; slave is the divider.
interface fp_div_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [4:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, flags
    );

endinterface

// File: rtl/fp_div_round_pack.sv
// Round-to-nearest-even, overflow/underflow detection and packing of the
// normalised quotient. Purely combinational; sampled by the ROUND state.
// Optional build macro: FP_DIV_SUBNORMAL_EN (gradual underflow). When it is
// undefined, tiny results flush to signed zero.
module fp_div_round_pack
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [MAN_W:0]           sig,
    input  logic                     guard,
    input  logic                     sticky,
    input  logic                     tiny,
    output logic [EXP_W+MAN_W:0]     res,
    output logic [FLG_W-1:0]         flags
);
    localparam int EW = EXP_W + 2;
    localparam int TOP = EXP_W + MAN_W;
    localparam logic signed [EW-1:0] MAX_E = EW'((1 << EXP_W) - 1);
    localparam logic [MAX_WORD-1:0] INF_FULL = fp_inf(EXP_W, MAN_W);
    localparam logic [TOP:0] INF_W = INF_FULL[TOP:0];

    logic                 round_up;
    logic                 inexact;
    logic [MAN_W+1:0]     sum;
    logic signed [EW-1:0] exp_r;
    logic [MAN_W-1:0]     frac;

    // RNE increment, carry handling (including subnormal -> normal), packing
    always_comb begin
        round_up = guard & (sticky | sig[0]);
        inexact  = guard | sticky;
        sum      = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
        if (sum[MAN_W+1]) begin
            exp_r = exp_in + EW'(1);
            frac  = '0;
        end else if ((exp_in == '0) && sum[MAN_W]) begin
            exp_r = EW'(1);
            frac  = sum[MAN_W-1:0];
        end else begin
            exp_r = exp_in;
            frac  = sum[MAN_W-1:0];
        end
        res           = {sign, exp_r[EXP_W-1:0], frac};
        flags         = '0;
        flags[FLG_NX] = inexact;
`ifdef FP_DIV_SUBNORMAL_EN
        flags[FLG_UF] = tiny & inexact;
        if (exp_r >= MAX_E) begin
            res           = INF_W;
            res[TOP]      = sign;
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end
`else
        if (tiny) begin
            res           = '0;
            res[TOP]      = sign;
            flags[FLG_UF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else if (exp_r >= MAX_E) begin
            res           = INF_W;
            res[TOP]      = sign;
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/fp_div_iter.sv
// Sequential IEEE-754 divider a/b: radix-2 restoring mantissa division,
// one quotient bit per cycle, exact RNE rounding and full exception flags.
// One operation in flight; valid/ready handshake on both sides.
// Optional build macro: FP_DIV_SUBNORMAL_EN -- subnormal operands are
// normalised and tiny results denormalised; otherwise flush-to-zero.
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst,
    fp_div_iter_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW  = EXP_W + 2;
    localparam int QW  = MAN_W + 3;
    localparam int CW  = $clog2(QW + 1);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [MAX_WORD-1:0] INF_FULL  = fp_inf(EXP_W, MAN_W);
    localparam logic [MAX_WORD-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] INF_W  = INF_FULL[W-1:0];
    localparam logic [W-1:0] QNAN_W = QNAN_FULL[W-1:0];

    state_t               state_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic [W-1:0]         res_reg;
    logic [FLG_W-1:0]     flags_reg;
    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic                 sign_reg;
    logic signed [EW-1:0] exp_reg;
    logic [MAN_W:0]       mb_reg;
    logic [MAN_W+1:0]     rem_reg;
    logic [QW-1:0]        quo_reg;
    logic [CW-1:0]        cnt_reg;
    logic [MAN_W:0]       sig_reg;
    logic                 guard_reg;
    logic                 sticky_reg;
    logic                 tiny_reg;

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.res       = res_reg;
    assign bus.flags     = flags_reg;

    // ---------------- operand classification (index 0 = a, 1 = b) ----------
    logic [W-1:0]         op_word [2];
    logic                 op_zero [2];
    logic                 op_inf  [2];
    logic                 op_nan  [2];
    logic                 op_snan [2];
    logic [MAN_W:0]       op_man  [2];
    logic signed [EW-1:0] op_exp  [2];

    assign op_word[0] = a_reg;
    assign op_word[1] = b_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [EXP_W-1:0] e_fld;
            logic [MAN_W-1:0] f_fld;
            assign e_fld       = op_word[gi][W-2 -: EXP_W];
            assign f_fld       = op_word[gi][MAN_W-1:0];
            assign op_nan[gi]  = (&e_fld) && (|f_fld);
            assign op_snan[gi] = op_nan[gi] && !f_fld[MAN_W-1];
            assign op_inf[gi]  = (&e_fld) && !(|f_fld);
`ifdef FP_DIV_SUBNORMAL_EN
            localparam int LZW = $clog2(MAN_W + 1);
            logic [LZW-1:0] lz;
            // Leading-zero count of the fraction, for subnormal normalisation
            always_comb begin
                lz = '0;
                for (int i = 0; i < MAN_W; i++) begin
                    if (f_fld[i]) lz = LZW'(MAN_W - 1 - i);
                end
            end
            assign op_zero[gi] = (e_fld == '0) && !(|f_fld);
            assign op_man[gi]  = (e_fld == '0) ? ({f_fld, 1'b0} << lz) : {1'b1, f_fld};
            assign op_exp[gi]  = (e_fld == '0) ? -$signed({{(EW-LZW){1'b0}}, lz})
                                               : $signed({2'b00, e_fld});
`else
            assign op_zero[gi] = (e_fld == '0);
            assign op_man[gi]  = {1'b1, f_fld};
            assign op_exp[gi]  = $signed({2'b00, e_fld});
`endif
        end
    endgenerate

    logic             sign_ab;
    logic             special;
    logic [W-1:0]     spec_res;
    logic [FLG_W-1:0] spec_flags;

    assign sign_ab = a_reg[W-1] ^ b_reg[W-1];

    // Special-operand results, highest priority first
    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (op_nan[0] || op_nan[1]) begin
            spec_res           = QNAN_W;
            spec_flags[FLG_NV] = op_snan[0] | op_snan[1];
        end else if ((op_zero[0] && op_zero[1]) || (op_inf[0] && op_inf[1])) begin
            spec_res           = QNAN_W;
            spec_flags[FLG_NV] = 1'b1;
        end else if (op_inf[0]) begin
            spec_res        = INF_W;
            spec_res[W-1]   = sign_ab;
        end else if (op_inf[1] || op_zero[0]) begin
            spec_res[W-1]   = sign_ab;
        end else if (op_zero[1]) begin
            spec_res           = INF_W;
            spec_res[W-1]      = sign_ab;
            spec_flags[FLG_DZ] = 1'b1;
        end else begin
            special = 1'b0;
        end
    end

    // ---------------- restoring division step ----------------
    logic             rem_ge;
    logic [MAN_W+1:0] rem_sub;
    logic [MAN_W+1:0] rem_next;

    // One quotient bit: subtract divisor when it fits, then shift remainder
    always_comb begin
        rem_ge   = (rem_reg >= {1'b0, mb_reg});
        rem_sub  = rem_ge ? (rem_reg - {1'b0, mb_reg}) : rem_reg;
        rem_next = rem_sub << 1;
    end

    // ---------------- normalisation ----------------
    logic [MAN_W:0]       n_sig;
    logic                 n_guard;
    logic                 n_sticky;
    logic signed [EW-1:0] n_exp;
    logic                 n_tiny;

    // Align quotient so the hidden bit is at MAN_W; a leading 0 costs one exponent step
    always_comb begin
        if (quo_reg[QW-1]) begin
            n_sig    = quo_reg[QW-1 -: MAN_W+1];
            n_guard  = quo_reg[1];
            n_sticky = quo_reg[0] | (|rem_reg);
            n_exp    = exp_reg;
        end else begin
            n_sig    = quo_reg[QW-2 -: MAN_W+1];
            n_guard  = quo_reg[0];
            n_sticky = |rem_reg;
            n_exp    = exp_reg - EW'(1);
        end
        n_tiny = n_exp[EW-1] || (n_exp == '0);
    end

    logic [MAN_W:0]       d_sig;
    logic                 d_guard;
    logic                 d_sticky;
    logic signed [EW-1:0] d_exp;

`ifdef FP_DIV_SUBNORMAL_EN
    logic [MAN_W+1:0]     dn_x;
    logic [MAN_W+1:0]     dn_shr;
    logic [MAN_W+1:0]     dn_lost;
    logic signed [EW-1:0] dn_sh;

    // Tiny results: shift right by 1-e so the exponent field becomes 0
    always_comb begin
        dn_x     = {n_sig, n_guard};
        dn_sh    = EW'(1) - n_exp;
        dn_shr   = dn_x >> dn_sh;
        dn_lost  = dn_x & ~({(MAN_W+2){1'b1}} << dn_sh);
        d_sig    = n_sig;
        d_guard  = n_guard;
        d_sticky = n_sticky;
        d_exp    = n_exp;
        if (n_tiny) begin
            d_sig    = dn_shr[MAN_W+1:1];
            d_guard  = dn_shr[0];
            d_sticky = n_sticky | (|dn_lost);
            d_exp    = '0;
        end
    end
`else
    assign d_sig    = n_sig;
    assign d_guard  = n_guard;
    assign d_sticky = n_sticky;
    assign d_exp    = n_exp;
`endif

    logic [W-1:0]     rp_res;
    logic [FLG_W-1:0] rp_flags;

    fp_div_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign   (sign_reg),
        .exp_in (exp_reg),
        .sig    (sig_reg),
        .guard  (guard_reg),
        .sticky (sticky_reg),
        .tiny   (tiny_reg),
        .res    (rp_res),
        .flags  (rp_flags)
    );

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            res_reg       <= '0;
            flags_reg     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mb_reg        <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            cnt_reg       <= '0;
            sig_reg       <= '0;
            guard_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            tiny_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        in_ready_reg <= 1'b0;
                        state_reg    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (special) begin
                        res_reg       <= spec_res;
                        flags_reg     <= spec_flags;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        sign_reg  <= sign_ab;
                        exp_reg   <= op_exp[0] - op_exp[1] + BIAS;
                        rem_reg   <= {1'b0, op_man[0]};
                        mb_reg    <= op_man[1];
                        quo_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    quo_reg <= {quo_reg[QW-2:0], rem_ge};
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(QW - 1)) state_reg <= S_NORM;
                end
                S_NORM: begin
                    sig_reg    <= d_sig;
                    guard_reg  <= d_guard;
                    sticky_reg <= d_sticky;
                    exp_reg    <= d_exp;
                    tiny_reg   <= n_tiny;
                    state_reg  <= S_ROUND;
                end
                S_ROUND: begin
                    res_reg       <= rp_res;
                    flags_reg     <= rp_flags;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
